// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// Each accepted request takes IDLE -> EXEC -> RESP, so a result is returned two cycles after its handshake.
module alu_arbiter #(
   parameter int DW = 4,
   parameter int SW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   input  logic          req1_valid,
   output logic          req0_ready,
   output logic          req1_ready,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   input  logic [SW-1:0] req0_sel,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   input  logic [SW-1:0] req1_sel,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [SW-1:0] alu_sel,
   input  logic [DW:0]   alu_out,
   output logic          rsp_valid,
   output logic          rsp_id,
   output logic [DW:0]   rsp_data,
   output logic          busy,
   output logic [7:0]    op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state, state_nxt;
   logic   last_grant;
   logic   grant;
   logic   gnt_id;
   logic   hs;

   logic [1:0][DW-1:0] a_vec, b_vec;
   logic [1:0][SW-1:0] sel_vec;

   assign a_vec   = {req1_a, req0_a};
   assign b_vec   = {req1_b, req0_b};
   assign sel_vec = {req1_sel, req0_sel};

   // Contention goes to whoever did not win last; a lone requester always wins.
   always_comb begin
      state_nxt = state;
      hs        = 1'b0;
      grant     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      case (state)
         IDLE: if (req0_valid || req1_valid) begin
            hs        = 1'b1;
            state_nxt = EXEC;
         end
         EXEC:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Reset overrides any handshake offered in the same cycle.
      if (rst) begin
         hs = 1'b0;
      end
   end

   assign req0_ready = hs && !grant;
   assign req1_ready = hs && grant;
   assign rsp_valid  = (state == RESP);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt_id     <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
         rsp_data   <= '0;
         rsp_id     <= 1'b0;
         op_count   <= '0;
      end else begin
         state <= state_nxt;
         if (hs) begin
            alu_a      <= a_vec[grant];
            alu_b      <= b_vec[grant];
            alu_sel    <= sel_vec[grant];
            gnt_id     <= grant;
            last_grant <= grant;
         end
         if (state == EXEC) begin
            rsp_data <= alu_out;
            rsp_id   <= gnt_id;
         end
         if (state == RESP) begin
            op_count <= op_count + 8'd1;
         end
      end
   end

endmodule
